// File: rtl/mha_result_collector_pkg.sv
// Shared constants, drain-state encoding and the slice helper used by the
// result collector and the ping-pong buffers.
package mha_result_collector_pkg;

    localparam int PKG_TOTAL_MODULES = 4;
    localparam int PKG_SLICE_WIDTH   = 64;
    localparam int PKG_COL_Y         = 2;
    localparam int PKG_ROW_CNT_W     = 16;
    localparam int PKG_RES_WIDTH     = PKG_TOTAL_MODULES * PKG_SLICE_WIDTH;
    localparam int PKG_SLICE_IDX_W   = (PKG_TOTAL_MODULES > 1) ? $clog2(PKG_TOTAL_MODULES) : 1;

    typedef logic [0:0] collector_state_t;
    localparam collector_state_t S_IDLE  = 1'b0;
    localparam collector_state_t S_DRAIN = 1'b1;

    // Slice 0 is the least significant SLICE_WIDTH bits of the word.
    function automatic logic [PKG_SLICE_WIDTH-1:0] extract_slice(
        input logic [PKG_RES_WIDTH-1:0]   word,
        input logic [PKG_SLICE_IDX_W-1:0] idx
    );
        return word[idx*PKG_SLICE_WIDTH +: PKG_SLICE_WIDTH];
    endfunction

endpackage

// File: rtl/mha_result_collector_if.sv
// Capture strobe from the matmul wrap plus the sliced output stream to the
// next MHA stage.
interface mha_result_collector_if #(
    parameter int TOTAL_MODULES = mha_result_collector_pkg::PKG_TOTAL_MODULES,
    parameter int SLICE_WIDTH   = mha_result_collector_pkg::PKG_SLICE_WIDTH
);
    localparam int RES_WIDTH = TOTAL_MODULES * SLICE_WIDTH;

    logic                   res_valid;
    logic [RES_WIDTH-1:0]   res_data;
    logic                   stall_req;

    // Output handshake: a beat moves on a posedge with m_valid && m_ready.
    // Once m_valid rises it stays high, and m_data/m_last hold, until that beat moves.
    logic                   m_valid;
    logic                   m_ready;
    logic [SLICE_WIDTH-1:0] m_data;
    logic                   m_last;

    modport slave (
        input  res_valid, res_data, m_ready,
        output stall_req, m_valid, m_data, m_last
    );

    modport master (
        output res_valid, res_data, m_ready,
        input  stall_req, m_valid, m_data, m_last
    );

endinterface

// File: rtl/mha_result_collector_out_row_bank.sv
// Two row banks of COL_Y result words: one write port, combinational read.
// Contents are never reset; bank validity lives in the collector.
module mha_result_collector_out_row_bank #(
    parameter int COL_Y     = 2,
    parameter int COL_W     = 1,
    parameter int RES_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic                 wr_bank_i,
    input  logic [COL_W-1:0]     wr_col_i,
    input  logic [RES_WIDTH-1:0] wr_data_i,
    input  logic                 rd_bank_i,
    input  logic [COL_W-1:0]     rd_col_i,
    output logic [RES_WIDTH-1:0] rd_data_o
);

    logic [RES_WIDTH-1:0] mem_q [2][COL_Y];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_bank_i][wr_col_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_bank_i][rd_col_i];

endmodule

// File: rtl/mha_result_collector.sv
// Collects COL_Y block results into ping-pong rows and streams each row out
// as TOTAL_MODULES slices per result.
module mha_result_collector
    import mha_result_collector_pkg::*;
#(
    parameter int TOTAL_MODULES = PKG_TOTAL_MODULES,
    parameter int SLICE_WIDTH   = PKG_SLICE_WIDTH,
    parameter int COL_Y         = PKG_COL_Y,
    parameter int ROW_CNT_W     = PKG_ROW_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    mha_result_collector_if.slave  bus,
    output logic [ROW_CNT_W-1:0]   rows_out,
    output logic                   overflow,
    output collector_state_t       dbg_state_o,
    output logic [1:0]             dbg_bank_full_o
);

    localparam int RES_WIDTH = TOTAL_MODULES * SLICE_WIDTH;
    localparam int COL_W     = (COL_Y > 1) ? $clog2(COL_Y) : 1;
    localparam int SL_W      = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COL_Y - 1);
    localparam logic [SL_W-1:0]  LAST_SLICE = SL_W'(TOTAL_MODULES - 1);

    collector_state_t     state_q, state_d;
    logic [1:0]           bank_full_q, bank_full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [COL_W-1:0]     wr_col_q, wr_col_d;
    logic [COL_W-1:0]     rd_col_q, rd_col_d;
    logic [SL_W-1:0]      slice_q, slice_d;
    logic [ROW_CNT_W-1:0] rows_q, rows_d;
    logic                 overflow_q, overflow_d;

    logic                 capture;
    logic                 beat_hs;
    logic                 row_end;
    logic [RES_WIDTH-1:0] rd_word;

    // Only registered fullness gates capture, so a bank freed this cycle waits a cycle.
    assign capture = bus.res_valid && !bank_full_q[wr_bank_q];
    assign beat_hs = (state_q == S_DRAIN) && bus.m_ready;
    assign row_end = (state_q == S_DRAIN) && (rd_col_q == LAST_COL) && (slice_q == LAST_SLICE);

    mha_result_collector_out_row_bank #(
        .COL_Y     (COL_Y),
        .COL_W     (COL_W),
        .RES_WIDTH (RES_WIDTH)
    ) u_bank (
        .clk       (clk),
        .we_i      (capture),
        .wr_bank_i (wr_bank_q),
        .wr_col_i  (wr_col_q),
        .wr_data_i (bus.res_data),
        .rd_bank_i (rd_bank_q),
        .rd_col_i  (rd_col_q),
        .rd_data_o (rd_word)
    );

    always_comb begin
        state_d     = state_q;
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_col_d    = wr_col_q;
        rd_col_d    = rd_col_q;
        slice_d     = slice_q;
        rows_d      = rows_q;
        overflow_d  = overflow_q;

        if (capture) begin
            if (wr_col_q == LAST_COL) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
                wr_col_d               = '0;
            end else begin
                wr_col_d = wr_col_q + COL_W'(1);
            end
        end
        if (bus.res_valid && !capture) begin
            overflow_d = 1'b1;
        end

        // Capture and drain always touch different banks, so both edits to bank_full_d stand.
        case (state_q)
            S_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d  = S_DRAIN;
                    rd_col_d = '0;
                    slice_d  = '0;
                end
            end
            default: begin
                if (beat_hs) begin
                    if (slice_q == LAST_SLICE) begin
                        slice_d  = '0;
                        rd_col_d = rd_col_q + COL_W'(1);
                    end else begin
                        slice_d = slice_q + SL_W'(1);
                    end
                    if (row_end) begin
                        bank_full_d[rd_bank_q] = 1'b0;
                        rd_bank_d              = ~rd_bank_q;
                        rd_col_d               = '0;
                        rows_d                 = rows_q + ROW_CNT_W'(1);
                        state_d                = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bank_full_q <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_col_q    <= '0;
            rd_col_q    <= '0;
            slice_q     <= '0;
            rows_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_col_q    <= wr_col_d;
            rd_col_q    <= rd_col_d;
            slice_q     <= slice_d;
            rows_q      <= rows_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.stall_req = bank_full_q[wr_bank_q];
    assign bus.m_valid   = (state_q == S_DRAIN);
    assign bus.m_data    = (state_q == S_DRAIN) ? extract_slice(rd_word, slice_q) : '0;
    assign bus.m_last    = row_end;

    assign rows_out        = rows_q;
    assign overflow        = overflow_q;
    assign dbg_state_o     = state_q;
    assign dbg_bank_full_o = bank_full_q;

endmodule

// File: tb/tb_mha_result_collector.sv
// Bench for mha_result_collector: directed scenarios plus randomized traffic
// against a row-queue model of the collector.
module tb_mha_result_collector;
    import mha_result_collector_pkg::*;

    localparam int TM = 4;
    localparam int SW = 64;
    localparam int CY = 2;
    localparam int RW = TM * SW;
    localparam int BW = SW + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      rows_out;
    logic             overflow;
    collector_state_t dbg_state;
    logic [1:0]       dbg_bank_full;

    mha_result_collector_if #(.TOTAL_MODULES(TM), .SLICE_WIDTH(SW)) bus ();

    mha_result_collector dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .rows_out        (rows_out),
        .overflow        (overflow),
        .dbg_state_o     (dbg_state),
        .dbg_bank_full_o (dbg_bank_full)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;

    logic [BW-1:0] exp_q[$];   // {last, slice} beats still owed by the DUT
    logic [BW-1:0] log_q[$];   // beats the DUT actually handed over
    logic [RW-1:0] part_q[$];  // results of the row being assembled
    int  m_full   = 0;         // rows stored and not yet fully drained
    bit  m_active = 1'b0;      // a row is being presented downstream
    int  m_rows   = 0;
    bit  m_ovf    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] mk_word(input int k);
        logic [RW-1:0] w;
        for (int s = 0; s < TM; s++) w[s*SW +: SW] = 64'(k * TM + s + 1);
        return w;
    endfunction

    function automatic logic [RW-1:0] rand_word();
        logic [RW-1:0] w;
        for (int i = 0; i < RW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Model update on each edge, from the inputs applied during the cycle.
    always @(posedge clk) begin : model
        bit            stall_now;
        bit            was_active;
        int            full_now;
        logic [BW-1:0] pop;
        logic [RW-1:0] w;
        if (rst) begin
            exp_q.delete();
            part_q.delete();
            log_q.delete();
            m_full   = 0;
            m_active = 1'b0;
            m_rows   = 0;
            m_ovf    = 1'b0;
        end else begin
            stall_now  = (m_full == 2);
            was_active = m_active;
            full_now   = m_full;
            if (bus.m_valid && bus.m_ready) log_q.push_back({bus.m_last, bus.m_data});
            if (was_active && bus.m_ready) begin
                pop = exp_q.pop_front();
                if (pop[SW]) begin
                    m_full--;
                    m_rows++;
                    m_active = 1'b0;
                end
            end else if (!was_active && full_now >= 1) begin
                m_active = 1'b1;
            end
            if (bus.res_valid) begin
                if (stall_now) begin
                    m_ovf = 1'b1;
                end else begin
                    part_q.push_back(bus.res_data);
                    if (part_q.size() == CY) begin
                        for (int c = 0; c < CY; c++) begin
                            w = part_q[c];
                            for (int s = 0; s < TM; s++)
                                exp_q.push_back({(c == CY - 1) && (s == TM - 1), w[s*SW +: SW]});
                        end
                        part_q.delete();
                        m_full++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin : compare
        logic [BW-1:0] head;
        if (!rst) begin
            check("m_valid", 64'(bus.m_valid), 64'(m_active));
            check("state", 64'(dbg_state), 64'(m_active));
            if (m_active) begin
                if (exp_q.size() == 0) begin
                    check("exp_empty", 64'(1), 64'(0));
                end else begin
                    head = exp_q[0];
                    check("m_data", bus.m_data, head[SW-1:0]);
                    check("m_last", 64'(bus.m_last), 64'(head[SW]));
                end
            end else begin
                check("m_data_idle", bus.m_data, 64'(0));
                check("m_last_idle", 64'(bus.m_last), 64'(0));
            end
            check("stall_req", 64'(bus.stall_req), 64'(m_full == 2));
            check("bank_full_cnt", 64'($countones(dbg_bank_full)), 64'(m_full));
            check("rows_out", 64'(rows_out), 64'(m_rows[15:0]));
            check("overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reset_checks();
        check("rst_m_valid", 64'(bus.m_valid), 64'(0));
        check("rst_m_data", bus.m_data, 64'(0));
        check("rst_m_last", 64'(bus.m_last), 64'(0));
        check("rst_stall", 64'(bus.stall_req), 64'(0));
        check("rst_rows", 64'(rows_out), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_bank_full", 64'(dbg_bank_full), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.res_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        reset_checks();
    endtask

    // Called at a negedge; the strobe is sampled by the next posedge.
    task automatic pulse(input logic [RW-1:0] d);
        bus.res_valid = 1'b1;
        bus.res_data  = d;
        @(negedge clk);
        bus.res_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(m_full == 0 && !m_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(n >= budget), 64'(0));
    endtask

    task automatic wait_beats(input int beats, input int budget);
        int n = 0;
        while (log_q.size() < beats && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("beat_timeout", 64'(n >= budget), 64'(0));
    endtask

    task automatic check_log(input string name, input int count, input int first);
        logic [BW-1:0] b;
        check({name, "_len"}, 64'(log_q.size()), 64'(count));
        for (int i = 0; i < count && i < log_q.size(); i++) begin
            b = log_q[i];
            check({name, "_data"}, b[SW-1:0], 64'(first + i));
            check({name, "_last"}, 64'(b[SW]), 64'((i % (TM * CY)) == TM * CY - 1));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.m_ready   = 1'b0;
        @(negedge clk);
        do_reset();

        // Single row and first-beat latency
        bus.m_ready = 1'b1;
        pulse(mk_word(0));
        pulse(mk_word(1));
        check("lat_edge_t", 64'(bus.m_valid), 64'(0));
        @(negedge clk);
        check("lat_edge_t1", 64'(bus.m_valid), 64'(1));
        wait_idle(100);
        check_log("single", 8, 1);
        check("single_rows", 64'(rows_out), 64'(1));

        // Backpressure mid-row
        do_reset();
        bus.m_ready = 1'b1;
        pulse(mk_word(0));
        pulse(mk_word(1));
        wait_beats(3, 50);
        bus.m_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_hold", 64'(bus.m_valid), 64'(1));
        end
        bus.m_ready = 1'b1;
        wait_idle(100);
        check_log("bp", 8, 1);

        // Ping-pong fill, then overflow while both banks are full
        do_reset();
        bus.m_ready = 1'b0;
        for (int k = 0; k < 4; k++) pulse(mk_word(k));
        check("pp_bank_full", 64'(dbg_bank_full), 64'(2'b11));
        check("pp_stall", 64'(bus.stall_req), 64'(1));
        pulse({{(RW-16){1'b0}}, 16'hDEAD});
        check("ovf_set", 64'(overflow), 64'(1));
        repeat (3) @(negedge clk);
        check("ovf_sticky", 64'(overflow), 64'(1));
        bus.m_ready = 1'b1;
        wait_idle(100);
        check_log("pp", 16, 1);
        check("pp_rows", 64'(rows_out), 64'(2));
        check("ovf_after", 64'(overflow), 64'(1));

        // Reset in the middle of a drain
        do_reset();
        bus.m_ready = 1'b1;
        pulse(mk_word(0));
        pulse(mk_word(1));
        wait_beats(3, 50);
        do_reset();
        pulse(mk_word(2));
        pulse(mk_word(3));
        wait_idle(100);
        check_log("mid_rst", 8, 9);

        // Capture completing bank 1 on the bank 0 m_last handshake
        do_reset();
        bus.m_ready = 1'b1;
        pulse(mk_word(0));
        pulse(mk_word(1));
        pulse(mk_word(2));
        repeat (7) @(negedge clk);
        check("conc_align_last", 64'(bus.m_last), 64'(1));
        pulse(mk_word(3));
        wait_idle(100);
        check_log("conc", 16, 1);
        check("conc_rows", 64'(rows_out), 64'(2));
        check("conc_ovf", 64'(overflow), 64'(0));

        // Randomized traffic within the stall protocol
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.m_ready   = ($urandom_range(0, 3) != 0);
            bus.res_valid = (m_full != 2) && ($urandom_range(0, 2) == 0);
            bus.res_data  = rand_word();
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        bus.m_ready   = 1'b1;
        wait_idle(200);
        check("rand_ovf", 64'(overflow), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
